// File: rtl/eth_rx_if.sv
// Byte-stream handshake between PHY byte source / payload consumer and eth_frame_rx.
interface eth_rx_if;
    logic       start;
    logic [7:0] in_data;
    logic       in_vld;
    logic       ready;
    logic [7:0] out_data;
    logic       out_vld;
    logic       out_last;
    logic       done;
    logic [2:0] err_code;
    logic       frame_drop;

    modport master (
        output start, in_data, in_vld,
        input  ready, out_data, out_vld, out_last, done, err_code, frame_drop
    );
    modport slave (
        input  start, in_data, in_vld,
        output ready, out_data, out_vld, out_last, done, err_code, frame_drop
    );
endinterface

// File: rtl/eth_frame_rx.sv
// Ethernet-style frame receiver: preamble/SFD, dest MAC filter, length, payload stream, LRC FCS, gap timeout.
// Define ETH_RX_BCAST_EN to also accept the all-FF broadcast destination.
module eth_frame_rx #(
    parameter logic [47:0] DEST_MAC_ADDR = 48'h00_0a_95_9d_68_16,
    parameter int          PREAMBLE_LEN  = 7,
    parameter int          FCS_LEN       = 4,
    parameter int          MAX_PAYLOAD   = 1500,
    parameter int          GAP_TIMEOUT   = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    eth_rx_if.slave  bus
);
`ifdef ETH_RX_BCAST_EN
    localparam logic BCAST = 1'b1;
`else
    localparam logic BCAST = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_LEN, S_PAY, S_FCS, S_REPORT
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] len;
    logic [15:0] pcnt;
    logic [15:0] gap_cnt;
    logic [7:0]  lrc;
    logic        own_ok;
    logic        bc_ok;

    wire [7:0]  b         = bus.in_data;
    wire [7:0]  dest_byte = 8'(DEST_MAC_ADDR >> {cnt, 3'b000});
    // Unicast and broadcast are tracked separately so a frame must match one of them on every byte.
    wire        own_n     = own_ok && (b == dest_byte);
    wire        bc_n      = bc_ok && BCAST && (b == 8'hFF);
    wire [15:0] len_n     = {b, len[7:0]};
    wire [7:0]  fcs_exp   = ~lrc + 8'd1;
    wire        active    = (state != S_IDLE) && (state != S_REPORT);
    wire        gap_exp   = (GAP_TIMEOUT != 0) && active && !bus.in_vld &&
                            (gap_cnt == 16'(GAP_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            len            <= '0;
            pcnt           <= '0;
            gap_cnt        <= '0;
            lrc            <= '0;
            own_ok         <= 1'b0;
            bc_ok          <= 1'b0;
            bus.ready      <= 1'b1;
            bus.out_data   <= '0;
            bus.out_vld    <= 1'b0;
            bus.out_last   <= 1'b0;
            bus.done       <= 1'b0;
            bus.err_code   <= '0;
            bus.frame_drop <= 1'b0;
        end else begin
            bus.out_vld    <= 1'b0;
            bus.out_last   <= 1'b0;
            bus.done       <= 1'b0;
            bus.frame_drop <= 1'b0;
            if (bus.in_vld)  gap_cnt <= '0;
            else if (active) gap_cnt <= gap_cnt + 16'd1;

            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    lrc     <= '0;
                    pcnt    <= '0;
                    gap_cnt <= '0;
                    if (bus.start && bus.in_vld) begin
                        bus.ready <= 1'b0;
                        if (b != 8'hAA) begin
                            state <= S_REPORT; bus.done <= 1'b1; bus.err_code <= 3'd1;
                        end else if (PREAMBLE_LEN == 1) begin
                            state <= S_SFD;
                        end else begin
                            state <= S_PRE;
                            cnt   <= 4'd1;
                        end
                    end
                end
                S_PRE: if (bus.in_vld) begin
                    if (b != 8'hAA) begin
                        state <= S_REPORT; bus.done <= 1'b1; bus.err_code <= 3'd1;
                    end else if (cnt == 4'(PREAMBLE_LEN - 1)) begin
                        state <= S_SFD;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_SFD: if (bus.in_vld) begin
                    if (b == 8'hAB) begin
                        state  <= S_DST;
                        cnt    <= '0;
                        own_ok <= 1'b1;
                        bc_ok  <= 1'b1;
                    end else begin
                        state <= S_REPORT; bus.done <= 1'b1; bus.err_code <= 3'd2;
                    end
                end
                S_DST: if (bus.in_vld) begin
                    lrc <= lrc + b;
                    if (!own_n && !bc_n) begin
                        bus.frame_drop <= 1'b1;
                        bus.ready      <= 1'b1;
                        state          <= S_IDLE;
                    end else begin
                        own_ok <= own_n;
                        bc_ok  <= bc_n;
                        if (cnt == 4'd5) begin
                            state <= S_SRC;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                S_SRC: if (bus.in_vld) begin
                    lrc <= lrc + b;
                    if (cnt == 4'd5) begin
                        state <= S_LEN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_LEN: if (bus.in_vld) begin
                    lrc <= lrc + b;
                    if (cnt == 4'd0) begin
                        len[7:0] <= b;
                        cnt      <= 4'd1;
                    end else begin
                        len  <= len_n;
                        pcnt <= '0;
                        if (len_n == 16'd0 || len_n > 16'(MAX_PAYLOAD)) begin
                            state <= S_REPORT; bus.done <= 1'b1; bus.err_code <= 3'd3;
                        end else begin
                            state <= S_PAY;
                        end
                    end
                end
                S_PAY: if (bus.in_vld) begin
                    lrc          <= lrc + b;
                    bus.out_data <= b;
                    bus.out_vld  <= 1'b1;
                    if (pcnt == len - 16'd1) begin
                        bus.out_last <= 1'b1;
                        state        <= S_FCS;
                        cnt          <= '0;
                    end else begin
                        pcnt <= pcnt + 16'd1;
                    end
                end
                S_FCS: if (bus.in_vld) begin
                    if (b != fcs_exp) begin
                        state <= S_REPORT; bus.done <= 1'b1; bus.err_code <= 3'd4;
                    end else if (cnt == 4'(FCS_LEN - 1)) begin
                        state <= S_REPORT; bus.done <= 1'b1; bus.err_code <= 3'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_REPORT: begin
                    bus.err_code <= '0;
                    bus.ready    <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // gap_exp implies no byte this cycle, so it never competes with a byte error
            if (gap_exp) begin
                state <= S_REPORT; bus.done <= 1'b1; bus.err_code <= 3'd5;
            end
        end
    end
endmodule

// File: tb/tb_eth_frame_rx.sv
// Randomized scoreboard bench for eth_frame_rx: frames built from field rules, expected outputs from a frame parser.
module tb_eth_frame_rx;
    localparam logic [47:0] DEST = 48'h00_0a_95_9d_68_16;
    localparam int PRE  = 7;
    localparam int FCSN = 4;
    localparam int MAXP = 24;
    localparam int GTO  = 16;
`ifdef ETH_RX_BCAST_EN
    localparam bit BC_OK = 1'b1;
`else
    localparam bit BC_OK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_rx_if bus();
    eth_frame_rx #(.DEST_MAC_ADDR(DEST), .PREAMBLE_LEN(PRE), .FCS_LEN(FCSN),
                   .MAX_PAYLOAD(MAXP), .GAP_TIMEOUT(GTO))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] exp_pay[$];
    int         exp_stat[$];
    logic [7:0] fr[$];
    int         gap[$];
    logic [8:0] m_pay[$];
    int         m_pidx[$];
    int         m_code, m_end, m_nsend;
    bit         m_tmo;
    logic [8:0] mon_e;
    int         mon_code, mon_s;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // monitor: consumes expected payload bytes and frame status (7 = silent drop)
    always @(negedge clk) if (rst_n) begin
        if (bus.out_vld) begin
            if (exp_pay.size() == 0) chk("unexpected_out_vld", 1, 0);
            else begin
                mon_e = exp_pay.pop_front();
                chk("payload_last_data", {23'd0, bus.out_last, bus.out_data}, {23'd0, mon_e});
            end
        end
        if (bus.done || bus.frame_drop) begin
            mon_code = bus.frame_drop ? 7 : int'(bus.err_code);
            if (exp_stat.size() == 0) chk("unexpected_status", mon_code, -1);
            else begin
                mon_s = exp_stat.pop_front();
                chk("status_code", mon_code, mon_s);
                if (mon_s != 5) chk("status_latency", cyc, acc_cyc);
            end
        end
    end

    // frame parser following the field rules; yields expected payload, code and last consumed byte
    task automatic parse();
        int len, base;
        logic [7:0] sum, fcs, bt;
        bit own, bc;
        m_pay.delete(); m_pidx.delete();
        own = 1; bc = 1; sum = 0;
        for (int k = 0; k < PRE; k++)
            if (fr[k] != 8'hAA) begin m_end = k; m_code = 1; return; end
        if (fr[PRE] != 8'hAB) begin m_end = PRE; m_code = 2; return; end
        for (int k = 0; k < 6; k++) begin
            bt  = fr[PRE+1+k];
            own = own && (bt == DEST[8*k +: 8]);
            bc  = bc && BC_OK && (bt == 8'hFF);
            if (!own && !bc) begin m_end = PRE + 1 + k; m_code = 7; return; end
        end
        for (int k = 1; k <= 14; k++) sum += fr[PRE+k];
        len = {16'd0, fr[PRE+14], fr[PRE+13]};
        if (len == 0 || len > MAXP) begin m_end = PRE + 14; m_code = 3; return; end
        base = PRE + 15;
        for (int k = 0; k < len; k++) begin
            m_pay.push_back({k == len - 1, fr[base+k]});
            m_pidx.push_back(base + k);
            sum += fr[base+k];
        end
        fcs = 8'(8'd0 - sum);
        for (int k = 0; k < FCSN; k++)
            if (fr[base+len+k] != fcs) begin m_end = base + len + k; m_code = 4; return; end
        m_end = base + len + FCSN - 1;
        m_code = 0;
    endtask

    task automatic model();
        parse();
        m_tmo = 0;
        m_nsend = m_end + 1;
        for (int i = 1; i <= m_end; i++)
            if (gap[i] >= GTO) begin m_tmo = 1; m_nsend = i; m_code = 5; break; end
        while (m_pidx.size() > 0 && m_pidx[m_pidx.size()-1] >= m_nsend) begin
            void'(m_pidx.pop_back());
            void'(m_pay.pop_back());
        end
    endtask

    // kinds: 0 good,1 preamble,2 SFD,3 dest,4 bcast,5 len0,6 len max+1,7 len max,8 fcs,9 timeout,10 gap-1,11 junk
    task automatic build(input int kind);
        int len, base, k;
        logic [7:0] sum;
        fr.delete(); gap.delete();
        len = $urandom_range(1, MAXP);
        if (kind == 5) len = 0;
        if (kind == 6) len = MAXP + 1;
        if (kind == 7) len = MAXP;
        if (kind == 9 || kind == 10) len = $urandom_range(2, MAXP);
        for (int i = 0; i < PRE; i++) fr.push_back(8'hAA);
        fr.push_back(8'hAB);
        for (int i = 0; i < 6; i++) fr.push_back(kind == 4 ? 8'hFF : DEST[8*i +: 8]);
        for (int i = 0; i < 6; i++) fr.push_back(8'($urandom));
        fr.push_back(len[7:0]);
        fr.push_back(len[15:8]);
        for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
        sum = 0;
        for (int i = PRE + 1; i < fr.size(); i++) sum += fr[i];
        for (int i = 0; i < FCSN; i++) fr.push_back(8'(8'd0 - sum));
        for (int i = 0; i < fr.size(); i++) gap.push_back($urandom_range(0, 2));
        base = PRE + 15;
        case (kind)
            1:  fr[$urandom_range(0, PRE-1)] = 8'h55;
            2:  fr[PRE] = 8'hAA;
            3:  begin k = $urandom_range(0, 5); fr[PRE+1+k] ^= 8'($urandom_range(1, 255)); end
            8:  fr[fr.size()-1] = fr[fr.size()-1] + 8'd1;
            9:  gap[base + $urandom_range(1, len-1)] = GTO;
            10: gap[base + $urandom_range(1, len-1)] = GTO - 1;
            11: begin
                k = $urandom_range(0, fr.size()-1);
                if (k == PRE + 13 || k == PRE + 14) k = PRE + 12;
                fr[k] = 8'($urandom);
            end
            default: ;
        endcase
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_vld = 1'b0;
        bus.start = 1'b0;
        bus.in_data = 8'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit st);
        @(negedge clk);
        bus.in_data = d;
        bus.in_vld = 1'b1;
        bus.start = st;
        acc_cyc = cyc + 1;
    endtask

    task automatic wait_ready();
        int k;
        idle();
        for (k = 0; k < 64 && bus.ready !== 1'b1; k++) idle();
        if (k == 64) chk("ready_timeout", int'(bus.ready), 1);
    endtask

    task automatic send_upto(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap[i]) idle();
            send_byte(fr[i], i == 0);
        end
    endtask

    task automatic run_frame();
        model();
        foreach (m_pay[i]) exp_pay.push_back(m_pay[i]);
        exp_stat.push_back(m_code);
        wait_ready();
        send_upto(m_nsend);
        if (m_tmo) repeat (gap[m_nsend]) idle();
        for (int k = 0; k < 64 && (exp_stat.size() != 0 || exp_pay.size() != 0); k++) idle();
        repeat (2) idle();
        chk("pay_queue_empty", exp_pay.size(), 0);
        chk("stat_queue_empty", exp_stat.size(), 0);
        chk("ready_after_frame", int'(bus.ready), 1);
        exp_pay.delete();
        exp_stat.delete();
    endtask

    initial begin
        bus.start = 1'b0; bus.in_vld = 1'b0; bus.in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_ready", int'(bus.ready), 1);
        chk("reset_out_vld", int'(bus.out_vld), 0);
        chk("reset_out_last", int'(bus.out_last), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_drop", int'(bus.frame_drop), 0);
        chk("reset_err_code", int'(bus.err_code), 0);
        rst_n = 1'b1;

        for (int r = 0; r < 2; r++)
            for (int kind = 0; kind < 12; kind++) begin build(kind); run_frame(); end
        for (int n = 0; n < 150; n++) begin build($urandom_range(0, 11)); run_frame(); end

        // reset while payload is streaming: three bytes out, then abort with no status
        do build(0); while ({fr[PRE+14], fr[PRE+13]} < 16'd4);
        model();
        for (int i = 0; i < 3; i++) exp_pay.push_back(m_pay[i]);
        wait_ready();
        send_upto(PRE + 18);
        idle();
        #2;
        chk("pre_reset_out_vld", int'(bus.out_vld), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", int'(bus.ready), 1);
        chk("midrst_out_vld", int'(bus.out_vld), 0);
        chk("midrst_out_data", int'(bus.out_data), 0);
        chk("midrst_done", int'(bus.done), 0);
        idle();
        rst_n = 1'b1;
        repeat (GTO + 4) idle();
        chk("midrst_pay_consumed", exp_pay.size(), 0);
        chk("midrst_ready_after", int'(bus.ready), 1);
        exp_pay.delete();
        build(0);
        run_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
